// File: rtl/pulse_expand_if.sv
// Single-wire width-coded link: the pulse source drives in, pulse_expand returns
// the expanded pulse plus status.
interface pulse_expand_if;
    logic       in;
    logic       out;
    logic       busy;
    logic [2:0] width;
    logic       width_vld;
    logic       err;

    modport master (output in, input  out, busy, width, width_vld, err);
    modport slave  (input  in, output out, busy, width, width_vld, err);
endinterface

// File: rtl/pulse_expand.sv
// Pulse-width decoder: measures each high pulse on in and replays it MULT times wider.
// Optional PULSE_EXP_ERR_EN enables the sticky err flag (rejects and overlaps).
module pulse_expand #(
    parameter int MULT  = 4,
    parameter int MAX_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    pulse_expand_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEAS, EMIT, DRAIN} state_t;

    localparam logic [5:0] MULT6  = 6'(MULT);
    localparam logic [2:0] MAX_W3 = 3'(MAX_W);

    state_t     state, state_nxt;
    logic [2:0] wcnt, wcnt_nxt;
    logic [5:0] ecnt, ecnt_nxt;
    logic       out_q, out_nxt;
    logic       vld_q, vld_nxt;
    logic [2:0] width_q, width_nxt;
    logic       fit;

    assign fit = (wcnt <= MAX_W3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wcnt    <= 3'd0;
            ecnt    <= 6'd0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            width_q <= 3'd0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            ecnt    <= ecnt_nxt;
            out_q   <= out_nxt;
            vld_q   <= vld_nxt;
            width_q <= width_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        ecnt_nxt  = ecnt;
        case (state)
            IDLE: begin
                if (bus.in) begin
                    state_nxt = MEAS;
                    wcnt_nxt  = 3'd1;
                end
            end
            MEAS: begin
                if (bus.in) begin
                    if (wcnt != 3'd7) wcnt_nxt = wcnt + 3'd1;
                end else if (fit) begin
                    state_nxt = EMIT;
                    ecnt_nxt  = MULT6 * {3'd0, wcnt} - 6'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            EMIT: begin
                // in is ignored here; a pulse still high at the end is drained unmeasured
                if (ecnt != 6'd0) ecnt_nxt = ecnt - 6'd1;
                else              state_nxt = bus.in ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!bus.in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_nxt   = (state_nxt == EMIT);
        vld_nxt   = (state == MEAS) && !bus.in && fit;
        width_nxt = vld_nxt ? wcnt : width_q;
    end

    assign bus.out       = out_q;
    assign bus.busy      = (state != IDLE);
    assign bus.width     = width_q;
    assign bus.width_vld = vld_q;

`ifdef PULSE_EXP_ERR_EN
    logic in_q, err_q;

    // rise of in while emitting, or a pulse too wide to accept
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            in_q <= bus.in;
            if ((state == EMIT && bus.in && !in_q) ||
                (state == MEAS && !bus.in && !fit))
                err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_pulse_expand.sv
// Bench for pulse_expand: two instances (MULT=4/MAX_W=6 and MULT=2/MAX_W=3) share one
// input and are compared each cycle against a timestamp-based pulse model.
module tb_pulse_expand;
`ifdef PULSE_EXP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int       meas_start;   // edge of first high sample, -1 when not measuring
        int       emit_last;    // edge at which the current expansion ends
        bit       drain;
        bit       prev;
        bit       out;
        bit       busy;
        bit       vld;
        bit [2:0] width;
        bit       err;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   t = 0;
    int   checks = 0;
    int   errors = 0;
    mdl_t ma, mb;

    pulse_expand_if bus_a ();
    pulse_expand_if bus_b ();

    pulse_expand #(.MULT(4), .MAX_W(6)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pulse_expand #(.MULT(2), .MAX_W(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    function automatic mdl_t mreset();
        mdl_t r;
        r.meas_start = -1; r.emit_last = -1; r.drain = 0; r.prev = 0;
        r.out = 0; r.busy = 0; r.vld = 0; r.width = 3'd0; r.err = 0;
        return r;
    endfunction

    // One sampled value v at edge number tt; pulse widths from timestamps.
    function automatic mdl_t mstep(mdl_t m, int tt, bit v, int mult, int maxw);
        mdl_t r = m;
        int   w;
        r.vld = 0;
        if (tt <= m.emit_last) begin
            if (ERR_EN && v && !m.prev) r.err = 1;
            if (tt == m.emit_last) begin r.out = 0; r.drain = v; end
            else r.out = 1;
        end else if (m.drain) begin
            if (!v) r.drain = 0;
        end else if (m.meas_start >= 0) begin
            if (!v) begin
                w = tt - m.meas_start;
                if (w > 7) w = 7;
                if (w <= maxw) begin
                    r.emit_last = tt + mult * w;
                    r.out = 1; r.vld = 1; r.width = w[2:0];
                end else if (ERR_EN) begin
                    r.err = 1;
                end
                r.meas_start = -1;
            end
        end else if (v) begin
            r.meas_start = tt;
        end
        r.prev = v;
        r.busy = (r.meas_start >= 0) || (tt < r.emit_last) || r.drain;
        return r;
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic step(bit v);
        bus_a.in = v;
        bus_b.in = v;
        @(posedge clk);
        #1;
        t++;
        if (rst) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, t, v, 4, 6);
            mb = mstep(mb, t, v, 2, 3);
        end
        check("a.out",       8'(bus_a.out),       8'(ma.out));
        check("a.busy",      8'(bus_a.busy),      8'(ma.busy));
        check("a.width_vld", 8'(bus_a.width_vld), 8'(ma.vld));
        check("a.width",     8'(bus_a.width),     8'(ma.width));
        check("a.err",       8'(bus_a.err),       8'(ma.err));
        check("b.out",       8'(bus_b.out),       8'(mb.out));
        check("b.busy",      8'(bus_b.busy),      8'(mb.busy));
        check("b.width_vld", 8'(bus_b.width_vld), 8'(mb.vld));
        check("b.width",     8'(bus_b.width),     8'(mb.width));
        check("b.err",       8'(bus_b.err),       8'(mb.err));
    endtask

    task automatic pulse(int hi, int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    initial begin
        bus_a.in = 1'b0;
        bus_b.in = 1'b0;
        ma = mreset();
        mb = mreset();

        // reset state
        rst = 1'b1;
        step(1'b0);
        step(1'b1);
        rst = 1'b0;
        step(1'b0);

        // basic widths: 2, then 1 and 6
        pulse(2, 12);
        pulse(1, 8);
        pulse(6, 30);

        // over-wide and saturating pulses are rejected
        pulse(7, 3);
        pulse(20, 3);

        // second pulse rises during EMIT and is drained unmeasured
        pulse(3, 5);
        pulse(15, 5);

        // reset in the middle of a 24-cycle expansion, then a normal pulse
        pulse(6, 4);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        pulse(2, 12);

        // reset with in already high: measurement starts fresh afterwards
        pulse(1, 0);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        pulse(2, 12);

        // widths 3 and 4: accepted then rejected by the MAX_W=3 instance
        pulse(3, 14);
        pulse(4, 20);

        // back-to-back with a single low cycle after expansion ends
        pulse(1, 5);
        pulse(1, 5);

        // randomized pulse trains
        repeat (60) pulse(int'($urandom_range(1, 9)), int'($urandom_range(1, 30)));
        repeat (10) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pulse_expand.md
# pulse_expand

Pulse-width decoder that undoes the 4:1 pulse-width compression used elsewhere in the design. It measures the width W of each high pulse on `in` and, after the pulse ends, drives `out` high for exactly MULT×W cycles. W is reported on a one-cycle `width`/`width_vld` strobe for logging. It sits on the receive side of the single-wire width-coded link, and its FSM style matches the compressor's.

## Interface
- `MULT`, default 4: expansion factor, 1..10.
- `MAX_W`, default 6: largest accepted width, 1..6. `MULT*MAX_W` must not exceed 63.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: one clock; reset is synchronous and active-high.
- `in` input 1: width-coded pulse, synchronous to `clk`.
- `out` output 1: expanded pulse, registered.
- `busy` output 1: high in any state other than IDLE.
- `width` output 3: measured W, valid when `width_vld` is high.
- `width_vld` output 1: one-cycle strobe.
- `err` output 1: sticky error flag. Functional only with `PULSE_EXP_ERR_EN`.

## Operation
- Reset values: `out`=0, `busy`=0, `width`=0, `width_vld`=0, `err`=0; state=IDLE; both counters 0.
- Measure counter `wcnt` is 3 bits and saturates at 7. Emit counter `ecnt` is 6 bits.
- IDLE
  - `in`=1 → MEAS, `wcnt`=1.
  - `in`=0 → stay in IDLE.
- MEAS
  - `in`=1 → `wcnt`=min(`wcnt`+1, 7).
  - `in`=0 with `wcnt`≤MAX_W → EMIT, `ecnt`=MULT×`wcnt`−1, `out`=1, `width`=`wcnt`, `width_vld`=1.
  - `in`=0 with `wcnt`>MAX_W → reject: go to IDLE, `out` stays 0, no `width_vld`.
- EMIT
  - `out`=1 while in this state.
  - `in` is ignored for measurement.
  - `ecnt`≠0 → decrement.
  - `ecnt`=0 and `in`=0 → IDLE, `out`=0.
  - `ecnt`=0 and `in`=1 → DRAIN, `out`=0.
- DRAIN
  - `out`=0.
  - Stay until `in`=0, then go to IDLE.
  - A pulse that was already high when EMIT finished is never measured (no partial measurement).
- `width_vld` is high for exactly one cycle per accepted pulse. `width` holds its value until the next accepted pulse.
- `rst` in any state forces the reset values on the next edge, including mid-EMIT: `out` drops the cycle after `rst` is sampled. After reset, a pulse already high on `in` is treated as new: IDLE sees `in`=1 and starts measuring.

## Timing
- Let the first high sample of `in` be at edge k, and the first low sample at edge k+W.
- `out` and `width_vld` go high from edge k+W. This is one cycle after `in` falls.
- `out` stays high for MULT×W cycles and falls at edge k+W+MULT×W.
- Two pulses separated by a single low cycle are both measured, provided the second rises after EMIT completes. A rise during EMIT leads to DRAIN.
- Minimum `in` low time between back-to-back accepted pulses: 1 cycle after `out` falls.
- No backpressure; the block never stalls.

## Configuration
- Macro: `PULSE_EXP_ERR_EN`.
- Defined: `err` goes high at the edge after either of these events, and stays high until `rst`:
  - a rejected pulse (W>MAX_W);
  - a 0→1 transition on `in` sampled during EMIT.
- Not defined: `err` is tied to 0. Rejected pulses and overlapping pulses are dropped silently. All other behaviour is identical.

## Test plan
- `in` high 2 cycles → `out` high exactly 8 cycles, starting 1 cycle after `in` falls; `width`=2 with `width_vld` for 1 cycle.
- `in` high 1 cycle, then separately 6 cycles → `out` pulses of 4 and 24 cycles; `width` strobes 1 then 6.
- `in` high 7 and then 20 cycles → `out` stays 0, no `width_vld`, `busy` returns to 0. With the macro defined, `err`=1 after the first reject.
- `in` high 3 cycles, then high again 5 cycles after `out` rises and held for 15 cycles → `out` high 12 cycles then 0, DRAIN until `in` falls, no second `width_vld`. With the macro defined, `err`=1.
- `rst` asserted in cycle 5 of a 24-cycle EMIT → `out`=0 and all outputs at reset values on the next edge. A subsequent 2-cycle pulse gives a normal 8-cycle `out`.
- Build with `MULT`=2 and `MAX_W`=3: `in` widths 3 and 4 → `out` pulse of 6 cycles, then reject.
